// File: rtl/design_35.sv
// design_35: registered W-bit adder with a one-cycle start/valid handshake.
// Define DESIGN_35_ASSERT_EN to compile embedded SVA checks and their shadow registers.
module design_35 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
    output logic         valid
);

    logic [W-1:0] w_sum;
    logic [W-1:0] r_y;
    logic         r_valid;

    // W-bit add: the carry-out is discarded, so the result is modulo 2^W
    assign w_sum = a + b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_y     <= '0;
        end else begin
            r_valid <= start;
            if (start) begin
                r_y <= w_sum;
            end
        end
    end

    assign y     = r_y;
    assign valid = r_valid;

`ifdef DESIGN_35_ASSERT_EN
    logic [W-1:0] r_sh_a;
    logic [W-1:0] r_sh_b;
    logic [W-1:0] w_chk;

    // Operands of the previous cycle, kept apart from the datapath register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sh_a <= '0;
            r_sh_b <= '0;
        end else begin
            r_sh_a <= a;
            r_sh_b <= b;
        end
    end

    assign w_chk = r_sh_a + r_sh_b;

    a_rst_valid : assert property (
        @(posedge clk) !rst_n |-> !valid
    ) else $error("reset/valid");

    a_latency : assert property (
        @(posedge clk) disable iff (!rst_n) start |=> valid
    ) else $error("latency/valid");

    a_datapath : assert property (
        @(posedge clk) disable iff (!rst_n) valid |-> (y == w_chk)
    ) else $error("datapath");
`endif

endmodule

// File: tb/tb_design_35.sv
// tb_design_35: table-driven vectors plus a queue scoreboard for design_35 (W=8).
// Covers reset, basic/wrap sums, back-to-back starts, async reset and a random soak.
module tb_design_35;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] y;
    logic       valid;

    int n_pass;
    int n_total;

    typedef struct {
        logic       start;
        logic [7:0] a;
        logic [7:0] b;
        logic       exp_v;
        logic [7:0] exp_y;
    } vec_t;

    vec_t       tbl[9];
    logic [7:0] sb_q[$];

    design_35 #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .y     (y),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock edge, then settle away from the edge before sampling
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [7:0] exp_s;
        logic [7:0] last_y;

        n_pass  = 0;
        n_total = 0;

        tbl[0] = '{1'b1, 8'h12, 8'h34, 1'b1, 8'h46};
        tbl[1] = '{1'b0, 8'h00, 8'h00, 1'b0, 8'h46};
        tbl[2] = '{1'b1, 8'hFF, 8'h01, 1'b1, 8'h00};
        tbl[3] = '{1'b1, 8'hC8, 8'h64, 1'b1, 8'h2C};
        tbl[4] = '{1'b0, 8'hAA, 8'h55, 1'b0, 8'h2C};
        tbl[5] = '{1'b1, 8'd1,  8'd2,  1'b1, 8'd3};
        tbl[6] = '{1'b1, 8'd3,  8'd4,  1'b1, 8'd7};
        tbl[7] = '{1'b1, 8'd250, 8'd10, 1'b1, 8'd4};
        tbl[8] = '{1'b0, 8'd0,  8'd0,  1'b0, 8'd4};

        rst_n = 1'b0;
        start = 1'b1;
        a     = 8'd5;
        b     = 8'd7;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("reset_valid", int'(valid), 0);
            chk("reset_y", int'(y), 0);
        end

        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) begin
            start = tbl[i].start;
            a     = tbl[i].a;
            b     = tbl[i].b;
            tick();
            chk($sformatf("vec%0d_valid", i), int'(valid), int'(tbl[i].exp_v));
            chk($sformatf("vec%0d_y", i), int'(y), int'(tbl[i].exp_y));
        end

        // Async reset while valid is high, well before the next edge
        start = 1'b1;
        a     = 8'd9;
        b     = 8'd9;
        tick();
        chk("mid_pre_valid", int'(valid), 1);
        chk("mid_pre_y", int'(y), 18);
        start = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_valid", int'(valid), 0);
        chk("mid_async_y", int'(y), 0);
        tick();
        rst_n = 1'b1;

        last_y = 8'd0;
        for (int t = 0; t < 10; t++) begin
            ra    = 8'($urandom_range(0, 255));
            rb    = 8'($urandom_range(0, 255));
            exp_s = 8'((int'(ra) + int'(rb)) % 256);
            start = 1'b1;
            a     = ra;
            b     = rb;
            sb_q.push_back(exp_s);
            tick();
            start = 1'b0;
            a     = 8'($urandom_range(0, 255));
            b     = 8'($urandom_range(0, 255));
            chk("soak_valid", int'(valid), 1);
            if (valid) begin
                if (sb_q.size() == 0) begin
                    chk("soak_queue", 0, 1);
                end else begin
                    last_y = sb_q.pop_front();
                    chk("soak_y", int'(y), int'(last_y));
                end
            end
            for (int k = 0; k < 3; k++) begin
                tick();
                chk("soak_idle_valid", int'(valid), 0);
                chk("soak_hold_y", int'(y), int'(last_y));
            end
        end
        chk("soak_queue_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
